// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrl_state_e  : sequencer states (RUN, DRAIN, DUMP, HALTED)
//   REG_W         : register-number width
//   DEF_DRAIN_CYC : default cycles for a HALT in ID/EX to retire past WB
package pipe_ctrl_pkg;

  localparam int unsigned REG_W         = 3;
  localparam int unsigned DEF_DRAIN_CYC = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    DUMP   = 2'd2,
    HALTED = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/raw_detect.sv
// Combinational read-after-write detector.
// Flags when a register read in ID is the destination of an in-flight
// instruction in ID/EX or EX/MEM. MEM/WB producers are not checked because
// the register file forwards a same-cycle write to the read port.
//   id_rs/id_rt (+_valid)      : source registers of the ID instruction
//   idex_wreg/idex_regwrite    : producer in ID/EX
//   exmem_wreg/exmem_regwrite  : producer in EX/MEM
//   raw                        : hazard present
module raw_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_valid,
  input  logic             id_rt_valid,
  input  logic [REG_W-1:0] idex_wreg,
  input  logic             idex_regwrite,
  input  logic [REG_W-1:0] exmem_wreg,
  input  logic             exmem_regwrite,
  output logic             raw
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit = id_rs_valid &
             (((id_rs == idex_wreg)  & idex_regwrite) |
              ((id_rs == exmem_wreg) & exmem_regwrite));
    rt_hit = id_rt_valid &
             (((id_rt == idex_wreg)  & idex_regwrite) |
              ((id_rt == exmem_wreg) & exmem_regwrite));
    raw    = rs_hit | rt_hit;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt sequencer for the five-stage IF/ID/EX/MEM/WB pipeline.
// Latch controls are combinational from the registered state and current
// inputs. A HALT in ID is let into ID/EX, the pipe drains for DRAIN_CYC
// cycles, a one-cycle dump strobe fires, then everything stays stopped
// until reset.
//   clk, rst (async, active-low)
//   id_*                : ID-stage register reads and HALT flag
//   idex_*, exmem_*     : in-flight destination registers
//   ex_redirect         : taken branch/jump resolved in EX
//   mem_busy            : data memory stall
//   pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble,
//   ex_mem_we, mem_wb_we: pipeline latch controls
//   dump, halted        : halt sequencing status
//   stall_cnt           : saturating count of RUN cycles with pc_we=0
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned DRAIN_CYC = DEF_DRAIN_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_valid,
  input  logic             id_rt_valid,
  input  logic             id_halt,
  input  logic [REG_W-1:0] idex_wreg,
  input  logic             idex_regwrite,
  input  logic [REG_W-1:0] exmem_wreg,
  input  logic             exmem_regwrite,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_bubble,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             dump,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  ctrl_state_e   state;
  logic [DW-1:0] drain_cnt;
  logic          raw;

  raw_detect u_raw_detect (
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs_valid    (id_rs_valid),
    .id_rt_valid    (id_rt_valid),
    .idex_wreg      (idex_wreg),
    .idex_regwrite  (idex_regwrite),
    .exmem_wreg     (exmem_wreg),
    .exmem_regwrite (exmem_regwrite),
    .raw            (raw)
  );

  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    dump         = 1'b0;
    halted       = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_busy) begin
          // whole pipe frozen; defaults already hold every latch
        end else if (ex_redirect) begin
          pc_we        = 1'b1;
          if_id_we     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_we     = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_we    = 1'b1;
          mem_wb_we    = 1'b1;
        end else if (raw) begin
          id_ex_we     = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_we    = 1'b1;
          mem_wb_we    = 1'b1;
        end else if (id_halt) begin
          // HALT moves into ID/EX; fetch stops behind it
          id_ex_we  = 1'b1;
          ex_mem_we = 1'b1;
          mem_wb_we = 1'b1;
        end else begin
          pc_we     = 1'b1;
          if_id_we  = 1'b1;
          id_ex_we  = 1'b1;
          ex_mem_we = 1'b1;
          mem_wb_we = 1'b1;
        end
      end
      DRAIN: begin
        if (!mem_busy) begin
          id_ex_we     = 1'b1;
          id_ex_bubble = 1'b1;
          ex_mem_we    = 1'b1;
          mem_wb_we    = 1'b1;
        end
      end
      DUMP:   dump   = 1'b1;
      HALTED: halted = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (!pc_we && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
          if (!mem_busy && !ex_redirect && !raw && id_halt) begin
            state     <= DRAIN;
            drain_cnt <= DW'(DRAIN_CYC - 1);
          end
        end
        DRAIN: begin
          if (!mem_busy) begin
            if (drain_cnt == '0)
              state <= DUMP;
            else
              drain_cnt <= drain_cnt - DW'(1);
          end
        end
        DUMP:   state <= HALTED;
        HALTED: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Control outputs are compared as a packed word:
//   {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble,
//    ex_mem_we, mem_wb_we, dump, halted}
module tb_pipe_hazard_ctrl;

  localparam int unsigned CW = 4;

  localparam logic [8:0] C_RUN    = 9'b1_1_0_1_0_1_1_0_0;
  localparam logic [8:0] C_RAW    = 9'b0_0_0_1_1_1_1_0_0;
  localparam logic [8:0] C_REDIR  = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] C_FREEZE = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] C_HALT   = 9'b0_0_0_1_0_1_1_0_0;
  localparam logic [8:0] C_DRAIN  = 9'b0_0_0_1_1_1_1_0_0;
  localparam logic [8:0] C_DUMP   = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] C_HALTED = 9'b0_0_0_0_0_0_0_0_1;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    id_rs, id_rt, idex_wreg, exmem_wreg;
  logic          id_rs_valid, id_rt_valid, id_halt;
  logic          idex_regwrite, exmem_regwrite, ex_redirect, mem_busy;
  logic          pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble;
  logic          ex_mem_we, mem_wb_we, dump, halted;
  logic [CW-1:0] stall_cnt;
  logic [8:0]    ctl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ctl = {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble,
                ex_mem_we, mem_wb_we, dump, halted};

  pipe_hazard_ctrl #(.CNT_W(CW), .DRAIN_CYC(3)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid),
    .id_halt(id_halt),
    .idex_wreg(idex_wreg), .idex_regwrite(idex_regwrite),
    .exmem_wreg(exmem_wreg), .exmem_regwrite(exmem_regwrite),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_we(id_ex_we), .id_ex_bubble(id_ex_bubble),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .dump(dump), .halted(halted), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_rs_valid = 0; id_rt_valid = 0; id_halt = 0;
    idex_wreg = '0; idex_regwrite = 0; exmem_wreg = '0; exmem_regwrite = 0;
    ex_redirect = 0; mem_busy = 0;
  endtask

  // advance one rising edge and settle just past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #1;
    chk("reset_ctl", 16'(ctl), 16'(C_RUN));
    chk("reset_cnt", 16'(stall_cnt), 16'd0);
    tick();
    rst = 1'b1;

    // RAW against ID/EX producer
    id_rs = 3'd3; id_rs_valid = 1; idex_wreg = 3'd3; idex_regwrite = 1;
    #1 chk("raw_idex_ctl", 16'(ctl), 16'(C_RAW));
    tick();
    chk("raw_idex_cnt", 16'(stall_cnt), 16'd1);

    // same conflict with redirect: redirect wins, no stall counted
    ex_redirect = 1;
    #1 chk("redir_ctl", 16'(ctl), 16'(C_REDIR));
    tick();
    chk("redir_cnt", 16'(stall_cnt), 16'd1);
    idle();

    // EX/MEM match but not writing: no hazard; then writing: hazard
    id_rt = 3'd5; id_rt_valid = 1; exmem_wreg = 3'd5;
    #1 chk("nowrite_ctl", 16'(ctl), 16'(C_RUN));
    exmem_regwrite = 1;
    #1 chk("raw_exmem_ctl", 16'(ctl), 16'(C_RAW));
    id_rt_valid = 0;
    #1 chk("rt_invalid_ctl", 16'(ctl), 16'(C_RUN));
    idle();

    // mem_busy beats redirect
    mem_busy = 1; ex_redirect = 1;
    #1 chk("freeze_ctl", 16'(ctl), 16'(C_FREEZE));
    tick();
    chk("freeze_cnt", 16'(stall_cnt), 16'd2);
    idle();

    // HALT: 3 DRAIN cycles, DUMP on the 4th, HALTED afterwards
    id_halt = 1;
    #1 chk("halt_ctl", 16'(ctl), 16'(C_HALT));
    tick();
    id_halt = 0;
    chk("halt_cnt", 16'(stall_cnt), 16'd3);
    chk("drain1", 16'(ctl), 16'(C_DRAIN));
    tick();
    chk("drain2", 16'(ctl), 16'(C_DRAIN));
    tick();
    chk("drain3", 16'(ctl), 16'(C_DRAIN));
    tick();
    chk("dump", 16'(ctl), 16'(C_DUMP));
    tick();
    chk("halted1", 16'(ctl), 16'(C_HALTED));
    id_rs = 3'd1; id_rs_valid = 1; idex_wreg = 3'd1; idex_regwrite = 1;
    tick();
    chk("halted2", 16'(ctl), 16'(C_HALTED));
    chk("halted_cnt", 16'(stall_cnt), 16'd3);
    idle();

    // reset out of HALTED
    rst = 1'b0;
    #1 chk("rst2_ctl", 16'(ctl), 16'(C_RUN));
    chk("rst2_cnt", 16'(stall_cnt), 16'd0);
    tick();
    rst = 1'b1;

    // HALT with 2 busy cycles inside DRAIN: dump two edges later
    id_halt = 1;
    tick();
    id_halt = 0;
    chk("bd_cnt", 16'(stall_cnt), 16'd1);
    chk("bd_drain1", 16'(ctl), 16'(C_DRAIN));
    tick();
    mem_busy = 1;
    #1 chk("bd_busy1", 16'(ctl), 16'(C_FREEZE));
    tick();
    chk("bd_busy2", 16'(ctl), 16'(C_FREEZE));
    tick();
    mem_busy = 0;
    #1 chk("bd_drain2", 16'(ctl), 16'(C_DRAIN));
    tick();
    chk("bd_drain3", 16'(ctl), 16'(C_DRAIN));
    tick();
    chk("bd_dump", 16'(ctl), 16'(C_DUMP));
    tick();
    chk("bd_halted", 16'(ctl), 16'(C_HALTED));

    // reset mid-DRAIN: back to RUN, no dump
    rst = 1'b0;
    tick();
    rst = 1'b1;
    id_halt = 1;
    tick();
    id_halt = 0;
    tick();
    rst = 1'b0;
    #1 chk("middrain_ctl", 16'(ctl), 16'(C_RUN));
    chk("middrain_cnt", 16'(stall_cnt), 16'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("nodump", 16'(ctl), 16'(C_RUN));
    end

    // stall counter saturation
    id_rs = 3'd6; id_rs_valid = 1; exmem_wreg = 3'd6; exmem_regwrite = 1;
    for (int i = 0; i < 14; i++) tick();
    chk("cnt14", 16'(stall_cnt), 16'd14);
    tick();
    chk("cnt15", 16'(stall_cnt), 16'd15);
    for (int i = 0; i < 4; i++) tick();
    chk("cnt_sat", 16'(stall_cnt), 16'd15);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush/halt sequencer for the five-stage pipeline (IF, ID, EX, MEM, WB). It watches register-use fields in ID, destination fields in ID/EX and EX/MEM, the EX-stage redirect, and the data-memory busy flag. From these it drives the write-enable and flush/bubble controls of the PC and of the IF_ID, ID_EX, EX_MEM and MEM_WB latches. It also drains the pipeline on HALT and then raises the one-cycle memory dump.

## Interface
Parameters:
- CNT_W, 16, width of stall-cycle counter
- DRAIN_CYC, 3, cycles for a HALT in ID/EX to reach past WB

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- id_rs  in  3  source reg 1 of instruction in IF_ID
- id_rt  in  3  source reg 2 of instruction in IF_ID
- id_rs_valid  in  1  id_rs is actually read
- id_rt_valid  in  1  id_rt is actually read
- id_halt  in  1  instruction in IF_ID is HALT
- idex_wreg  in  3  destination reg in ID/EX
- idex_regwrite  in  1  ID/EX instruction writes the register file
- exmem_wreg  in  3  destination reg in EX/MEM
- exmem_regwrite  in  1  EX/MEM instruction writes the register file
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle
- mem_busy  in  1  data memory not done; MEM must hold
- pc_we  out  1  PC register load enable
- if_id_we  out  1  IF_ID latch enable
- if_id_flush  out  1  load NOP into IF_ID
- id_ex_we  out  1  ID_EX latch enable
- id_ex_bubble  out  1  load all-zero controls into ID_EX
- ex_mem_we  out  1  EX_MEM latch enable
- mem_wb_we  out  1  MEM_WB latch enable
- dump  out  1  memory dump strobe, one cycle
- halted  out  1  pipeline stopped after HALT
- stall_cnt  out  CNT_W  saturating count of cycles with pc_we=0 in RUN

## Operation
- FSM states: RUN, DRAIN, DUMP, HALTED. Reset: state=RUN, drain_cnt=0, stall_cnt=0.
- raw = (id_rs_valid & (id_rs==idex_wreg & idex_regwrite | id_rs==exmem_wreg & exmem_regwrite)) | the same check for id_rt. MEM_WB hazards are excluded because the register file bypasses write-to-read.
- RUN priority, highest first:
  - mem_busy: all five enables = 0, no flush/bubble.
  - ex_redirect: pc_we=1, if_id_flush=1, id_ex_bubble=1, all other enables=1. Any raw or id_halt is discarded.
  - raw: pc_we=0, if_id_we=0, id_ex_bubble=1, ex_mem_we=mem_wb_we=1.
  - id_halt: pc_we=0, if_id_we=0, and the HALT advances into ID/EX. Next state DRAIN, drain_cnt=DRAIN_CYC-1.
  - else: all enables=1.
- DRAIN:
  - pc_we=0, if_id_we=0, id_ex_bubble=1, downstream enables=1.
  - mem_busy freezes downstream and holds drain_cnt.
  - Otherwise drain_cnt decrements; at 0 the next state is DUMP.
- DUMP: dump=1 for exactly one cycle, all enables 0. Next state HALTED.
- HALTED: all enables 0, halted=1. The only exit is rst.
- stall_cnt increments in RUN when pc_we=0 and saturates at all-ones.
- Inactive outputs default to 0.

## Timing
- Outputs are combinational from the registered state and current inputs: zero-cycle latency.
- State, drain_cnt and stall_cnt update on the rising clk edge.
- rst low clears all state immediately. During reset the outputs reflect RUN with current inputs: dump=0, halted=0, stall_cnt=0.
- A reset mid-DRAIN returns the FSM to RUN with no dump.
- Load-use and RAW stalls last up to 2 cycles, until the producer leaves EX/MEM.
- ex_redirect and raw in the same cycle: redirect wins, no stall.
- HALT to dump: DRAIN_CYC+1 edges, with no mem_busy.
- mem_busy in the same cycle as ex_redirect: freeze wins. The redirect is re-evaluated the next cycle because EX is held.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, DRAIN, DUMP, HALTED);
  - REG_W=3;
  - the default DRAIN_CYC.
- One sub-module: raw_detect, the purely combinational comparator producing raw. The FSM and counters stay in the top level.

## Test plan
- id_rs=3 valid, idex_wreg=3 with regwrite, for 1 cycle -> pc_we=0, if_id_we=0, id_ex_bubble=1, stall_cnt goes 0->1.
- Same conflict plus ex_redirect=1 -> pc_we=1, if_id_flush=1, id_ex_bubble=1, stall_cnt unchanged.
- id_rt=5 vs exmem_wreg=5 with exmem_regwrite=0 -> no stall, all enables 1.
- id_halt=1 with DRAIN_CYC=3 and no mem_busy -> DRAIN for 3 cycles, dump=1 on the 4th cycle only, halted=1 from the 5th onward.
- mem_busy=1 for 2 cycles during DRAIN -> drain_cnt holds, dump is delayed by exactly 2 cycles.
- Assert rst low mid-DRAIN -> state RUN, stall_cnt=0, dump never pulses.
